irq_pending_capture: RTL and testbench
======================================

IRQ_PENDING_CAPTURE -- requirements
Module: irq_pending_capture

Interface
REQ-001 SHALL have parameter N, default 4: number of request lines; N>=2.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port req, input, N: level request lines; a rising edge on a line is one event.
REQ-005 SHALL have port mask, input, N: 1 = line excluded from selection; pending capture still occurs.
REQ-006 SHALL have port out_valid, output, 1: an index is offered.
REQ-007 SHALL have port out_ready, input, 1: consumer accepts the offered index.
REQ-008 SHALL have port out_idx, output, $clog2(N): offered line index.
REQ-009 SHALL have port pending, output, N: registered pending vector.
REQ-010 SHALL have port overrun, output, N: sticky per-line lost-event flags.
REQ-011 SHALL have port clr_overrun, input, 1: one-cycle pulse that clears all overrun bits.

Function
REQ-012 SHALL register req into req_d each cycle; edge = req & ~req_d.
REQ-013 SHALL set pending[i] on the clock edge where edge[i]=1.
REQ-014 SHALL clear pending[i] on a handshake (out_valid & out_ready) with out_idx=i.
REQ-015 SHALL keep pending[i]=1 without setting overrun[i] when edge[i] and the clear for i occur in the same cycle; set wins.
REQ-016 SHALL set overrun[i] when edge[i]=1, pending[i] is already 1, and i is not being cleared in that cycle.
REQ-017 SHALL give an overrun[i] set precedence over clr_overrun in the same cycle.
REQ-018 SHALL select as candidate the highest index i with pending[i] & ~mask[i] = 1; index N-1 has top priority.
REQ-019 SHALL implement a two-state FSM with states IDLE and OFFER.
REQ-020 SHALL, in IDLE with a nonzero candidate set, load out_idx with the candidate and move to OFFER; otherwise it stays in IDLE.
REQ-021 SHALL drive out_valid=1 exactly when in OFFER.
REQ-022 SHALL hold out_idx stable in OFFER until the handshake, even when a higher-priority line becomes pending or mask changes; an offer is never retracted.
REQ-023 SHALL return from OFFER to IDLE on handshake, giving one bubble cycle; maximum throughput is one index per 2 cycles.
REQ-024 SHALL have a latency of 2 clock edges from the first edge sampling req[i]=1 to out_valid=1, when idle and unmasked.
REQ-025 SHALL let a handshake clear a line that became masked after the offer was made.
REQ-026 SHALL use registered outputs only; no combinational path from req, mask or out_ready to out_valid or out_idx.

Reset
REQ-027 SHALL, with rst=1, force FSM=IDLE, out_valid=0, out_idx=0, pending=0, overrun=0, req_d=0.
REQ-028 SHALL count a req line held high through reset release as one event, captured on the first non-reset edge.
REQ-029 SHALL abandon any offer in progress when rst is asserted mid-offer; all pending state is lost.

Structure
REQ-030 SHALL take FSM state encodings (IDLE=0, OFFER=1) from a shared package, irq_pkg.
REQ-031 SHALL place the highest-set-index selection in one combinational sub-module, pending_priority_select (parameter N; inputs vec; outputs idx, any).

Verification
REQ-032 SHALL cover, with N=4: req=0001 rising with out_ready=1 -> out_valid=1 with out_idx=0 two edges later, then pending=0000.
REQ-033 SHALL cover: req=0101 rising together, out_ready=1 -> out_idx=2 first, a bubble cycle, then out_idx=0.
REQ-034 SHALL cover: OFFER idx=1 with out_ready=0, then req[3] rises -> out_idx stays 1 until accepted, then 3 is offered.
REQ-035 SHALL cover: mask=1000 and req[3] rises -> pending=1000 and out_valid stays 0; mask=0000 -> offer idx=3 after 1 edge.
REQ-036 SHALL cover: req[2] pulses twice with no accept -> overrun=0100; clr_overrun -> 0000; an edge coincident with the clear of the same line -> no overrun.
REQ-037 SHALL cover: rst asserted during OFFER with req=1111 held -> all outputs 0; after release all four lines pend and are offered 3,2,1,0.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt pending-capture block: offer FSM
// state encodings and the handshake helper.
package irq_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } irq_state_e;

    function automatic logic is_handshake(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/pending_priority_select.sv
// Combinational highest-set-index selector: index N-1 has top priority.
module pending_priority_select #(
    parameter int N = 4
) (
    input  logic [N-1:0]         vec,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int IDXW = $clog2(N);

    // Ascending scan; the last set bit seen is the highest one.
    always_comb begin
        idx = {IDXW{1'b0}};
        any = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = IDXW'(i);
                any = 1'b1;
            end else begin
                idx = idx;
                any = any;
            end
        end
    end

endmodule

// File: rtl/irq_pending_capture.sv
// Captures rising edges on N request lines into a pending vector, tracks lost
// events as sticky overruns, and offers the highest unmasked pending index.
module irq_pending_capture
    import irq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_idx,
    output logic [N-1:0]         pending,
    output logic [N-1:0]         overrun,
    input  logic                 clr_overrun
);

    localparam int IDXW = $clog2(N);

    logic [N-1:0]    req_d_q;
    logic [N-1:0]    req_d_d;
    logic [N-1:0]    pending_q;
    logic [N-1:0]    pending_d;
    logic [N-1:0]    overrun_q;
    logic [N-1:0]    overrun_d;
    logic [N-1:0]    edge_s;
    logic [N-1:0]    clr_vec_s;
    logic [N-1:0]    ovr_set_s;
    logic [N-1:0]    cand_vec_s;
    logic [IDXW-1:0] cand_idx_s;
    logic            cand_any_s;
    logic            hs_s;
    logic [IDXW-1:0] out_idx_q;
    logic [IDXW-1:0] out_idx_d;
    logic            out_valid_q;
    logic            out_valid_d;
    irq_state_e      state_q;
    irq_state_e      state_d;

    pending_priority_select #(
        .N (N)
    ) u_select (
        .vec (cand_vec_s),
        .idx (cand_idx_s),
        .any (cand_any_s)
    );

    // Edge detection, handshake clear vector and candidate set.
    always_comb begin
        req_d_d    = req;
        edge_s     = req & ~req_d_q;
        hs_s       = is_handshake(out_valid_q, out_ready);
        clr_vec_s  = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            clr_vec_s[i] = hs_s && (out_idx_q == IDXW'(i));
        end
        cand_vec_s = pending_q & ~mask;
    end

    // A new edge always wins over a same-cycle clear and never counts as lost
    // in that case; an overrun set also wins over clr_overrun.
    always_comb begin
        ovr_set_s = edge_s & pending_q & ~clr_vec_s;
        pending_d = (pending_q & ~clr_vec_s) | edge_s;
        if (clr_overrun) begin
            overrun_d = ovr_set_s;
        end else begin
            overrun_d = overrun_q | ovr_set_s;
        end
    end

    // Offer FSM next state; the offered index is frozen until accepted.
    always_comb begin
        state_d     = state_q;
        out_idx_d   = out_idx_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (cand_any_s) begin
                    state_d     = OFFER;
                    out_idx_d   = cand_idx_s;
                    out_valid_d = 1'b1;
                end else begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            OFFER: begin
                if (hs_s) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    state_d     = OFFER;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_idx_d   = {IDXW{1'b0}};
                out_valid_d = 1'b0;
            end
        endcase
    end

    // All state, including registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_idx_q   <= {IDXW{1'b0}};
            pending_q   <= {N{1'b0}};
            overrun_q   <= {N{1'b0}};
            req_d_q     <= {N{1'b0}};
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            req_d_q     <= req_d_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pending   = pending_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_irq_pending_capture.sv
// Directed and randomized bench for irq_pending_capture (N=4) against a
// per-line behavioural model of the capture and offer rules.
module tb_irq_pending_capture;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_idx;
    logic [N-1:0] pending;
    logic [N-1:0] overrun;
    logic         clr_overrun;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    bit m_prev[N];
    bit m_pend[N];
    bit m_ovr[N];
    bit m_offer;
    int m_idx;

    irq_pending_capture #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .mask        (mask),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_idx     (out_idx),
        .pending     (pending),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] pack(input bit v[N]);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = v[i];
        return r;
    endfunction

    // One clock of the model, using inputs as they stand before the edge.
    task automatic model_tick();
        bit hs;
        bit new_pend[N];
        bit new_ovr[N];
        int best;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_prev[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
            end
            m_offer = 0;
            m_idx   = 0;
            return;
        end
        hs = m_offer && out_ready;
        for (int i = 0; i < N; i++) begin
            bit rise, cleared;
            rise    = req[i] && !m_prev[i];
            cleared = hs && (m_idx == i);
            new_pend[i] = rise ? 1 : (cleared ? 0 : m_pend[i]);
            if (rise && m_pend[i] && !cleared) new_ovr[i] = 1;
            else new_ovr[i] = clr_overrun ? 0 : m_ovr[i];
        end
        if (m_offer) begin
            if (hs) m_offer = 0;
        end else begin
            best = -1;
            for (int i = 0; i < N; i++)
                if (m_pend[i] && !mask[i]) best = i;
            if (best >= 0) begin
                m_offer = 1;
                m_idx   = best;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = new_pend[i];
            m_ovr[i]  = new_ovr[i];
            m_prev[i] = req[i];
        end
    endtask

    task automatic cyc();
        model_tick();
        @(posedge clk);
        #1;
        check("valid", 32'(out_valid), 32'(m_offer));
        check("idx", 32'(out_idx), 32'(m_idx));
        check("pending", 32'(pending), 32'(pack(m_pend)));
        check("overrun", 32'(overrun), 32'(pack(m_ovr)));
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [1:0] idx,
                              input logic [N-1:0] pend, input logic [N-1:0] ovr);
        check({tag, "_valid"}, 32'(out_valid), 32'(v));
        if (v) check({tag, "_idx"}, 32'(out_idx), 32'(idx));
        check({tag, "_pending"}, 32'(pending), 32'(pend));
        check({tag, "_overrun"}, 32'(overrun), 32'(ovr));
    endtask

    initial begin
        rst = 1'b1; req = 4'b0000; mask = 4'b0000; out_ready = 1'b0; clr_overrun = 1'b0;
        cyc(); cyc();
        expect_out("reset", 1'b0, 2'd0, 4'b0000, 4'b0000);
        check("reset_idx", 32'(out_idx), 32'd0);
        rst = 1'b0;
        cyc();

        // Single line, accepted immediately.
        req = 4'b0001; out_ready = 1'b1;
        cyc(); expect_out("s1_e1", 1'b0, 2'd0, 4'b0001, 4'b0000);
        cyc(); expect_out("s1_e2", 1'b1, 2'd0, 4'b0001, 4'b0000);
        cyc(); expect_out("s1_e3", 1'b0, 2'd0, 4'b0000, 4'b0000);
        req = 4'b0000; cyc();

        // Two lines together: 2 first, bubble, then 0.
        req = 4'b0101;
        cyc(); expect_out("s2_e1", 1'b0, 2'd0, 4'b0101, 4'b0000);
        cyc(); expect_out("s2_e2", 1'b1, 2'd2, 4'b0101, 4'b0000);
        cyc(); expect_out("s2_bubble", 1'b0, 2'd0, 4'b0001, 4'b0000);
        cyc(); expect_out("s2_e4", 1'b1, 2'd0, 4'b0001, 4'b0000);
        cyc(); expect_out("s2_e5", 1'b0, 2'd0, 4'b0000, 4'b0000);
        req = 4'b0000; cyc();

        // Offer of 1 is held while a higher line arrives.
        out_ready = 1'b0; req = 4'b0010;
        cyc(); cyc(); expect_out("s3_offer1", 1'b1, 2'd1, 4'b0010, 4'b0000);
        req = 4'b1010;
        cyc(); expect_out("s3_hold_a", 1'b1, 2'd1, 4'b1010, 4'b0000);
        cyc(); expect_out("s3_hold_b", 1'b1, 2'd1, 4'b1010, 4'b0000);
        out_ready = 1'b1;
        cyc(); expect_out("s3_acc1", 1'b0, 2'd0, 4'b1000, 4'b0000);
        cyc(); expect_out("s3_offer3", 1'b1, 2'd3, 4'b1000, 4'b0000);
        cyc(); expect_out("s3_acc3", 1'b0, 2'd0, 4'b0000, 4'b0000);
        req = 4'b0000; cyc();

        // Masked line pends but is not offered until unmasked.
        mask = 4'b1000; req = 4'b1000;
        cyc(); expect_out("s4_pend", 1'b0, 2'd0, 4'b1000, 4'b0000);
        cyc(); cyc(); expect_out("s4_masked", 1'b0, 2'd0, 4'b1000, 4'b0000);
        mask = 4'b0000;
        cyc(); expect_out("s4_unmask", 1'b1, 2'd3, 4'b1000, 4'b0000);
        cyc(); expect_out("s4_acc", 1'b0, 2'd0, 4'b0000, 4'b0000);
        req = 4'b0000; cyc();

        // Overrun on a second pulse, clear, and no overrun on coincident clear.
        out_ready = 1'b0; req = 4'b0100;
        cyc(); cyc(); expect_out("s5_offer2", 1'b1, 2'd2, 4'b0100, 4'b0000);
        req = 4'b0000; cyc();
        req = 4'b0100;
        cyc(); expect_out("s5_ovr", 1'b1, 2'd2, 4'b0100, 4'b0100);
        req = 4'b0000; clr_overrun = 1'b1;
        cyc(); expect_out("s5_clr", 1'b1, 2'd2, 4'b0100, 4'b0000);
        clr_overrun = 1'b0; req = 4'b0100; out_ready = 1'b1;
        cyc(); expect_out("s5_coinc", 1'b0, 2'd0, 4'b0100, 4'b0000);
        cyc(); expect_out("s5_reoffer", 1'b1, 2'd2, 4'b0100, 4'b0000);
        cyc(); expect_out("s5_done", 1'b0, 2'd0, 4'b0000, 4'b0000);
        req = 4'b0000; cyc();

        // Reset mid-offer with all lines held high.
        out_ready = 1'b0; req = 4'b1111;
        cyc(); cyc(); expect_out("s6_offer3", 1'b1, 2'd3, 4'b1111, 4'b0000);
        rst = 1'b1;
        cyc(); expect_out("s6_rst", 1'b0, 2'd0, 4'b0000, 4'b0000);
        check("s6_rst_idx", 32'(out_idx), 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        cyc(); expect_out("s6_repend", 1'b0, 2'd0, 4'b1111, 4'b0000);
        cyc(); expect_out("s6_o3", 1'b1, 2'd3, 4'b1111, 4'b0000);
        cyc(); cyc(); expect_out("s6_o2", 1'b1, 2'd2, 4'b0011 | 4'b0100, 4'b0000);
        cyc(); cyc(); expect_out("s6_o1", 1'b1, 2'd1, 4'b0011, 4'b0000);
        cyc(); cyc(); expect_out("s6_o0", 1'b1, 2'd0, 4'b0001, 4'b0000);
        cyc(); expect_out("s6_empty", 1'b0, 2'd0, 4'b0000, 4'b0000);
        req = 4'b0000; cyc();

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            req         = 4'($urandom_range(0, 15));
            mask        = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            out_ready   = 1'($urandom_range(0, 1));
            clr_overrun = ($urandom_range(0, 9) == 0);
            rst         = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0; clr_overrun = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
